// File: rtl/fcs_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : fcs_sequencer
// Purpose : Frame sequencer that passes frame bytes through, zero-pads short
//           frames, then appends the 4-byte FCS from an external CRC-32 core.
// Revision: 1.0 - initial release
// ============================================================================
module fcs_sequencer #(
    parameter int MIN_LEN = 60,
    parameter bit PAD_EN  = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  s_data,
    input  logic        s_valid,
    input  logic        s_last,
    output logic        s_ready,
    output logic [7:0]  m_data,
    output logic        m_valid,
    output logic        m_last,
    input  logic        m_ready,
    output logic        crc_rst_n,
    output logic        crc_en,
    output logic [7:0]  crc_data,
    input  logic [31:0] crc_in,
    output logic        busy
);

    typedef enum logic [2:0] {
        ST_DATA  = 3'd0,
        ST_PAD   = 3'd1,
        ST_WAIT  = 3'd2,
        ST_FCS   = 3'd3,
        ST_CLEAR = 3'd4
    } state_t;

    localparam logic [10:0] c_CNT_MAX = 11'd2047;
    localparam logic [11:0] c_MIN_LEN = 12'(MIN_LEN);

    state_t      r_state, w_state_nx;
    logic [10:0] r_count, w_count_nx, w_count_sat;
    logic [11:0] w_count_p1;
    logic [1:0]  r_idx, w_idx_nx;
    logic [31:0] r_fcs, w_fcs_nx;
    logic [7:0]  w_m_data, w_crc_data;
    logic        w_m_valid, w_m_last, w_s_ready, w_crc_en;

    // Unsaturated count+1 for the pad decision, saturated copy for storage
    assign w_count_p1  = {1'b0, r_count} + 12'd1;
    assign w_count_sat = (r_count == c_CNT_MAX) ? r_count : (r_count + 11'd1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_DATA;
            r_count <= 11'd0;
            r_idx   <= 2'd0;
            r_fcs   <= 32'd0;
        end else begin
            r_state <= w_state_nx;
            r_count <= w_count_nx;
            r_idx   <= w_idx_nx;
            r_fcs   <= w_fcs_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_count_nx = r_count;
        w_idx_nx   = r_idx;
        w_fcs_nx   = r_fcs;
        w_m_data   = 8'h00;
        w_m_valid  = 1'b0;
        w_m_last   = 1'b0;
        w_s_ready  = 1'b0;
        w_crc_en   = 1'b0;
        w_crc_data = 8'h00;
        case (r_state)
            ST_DATA: begin
                w_m_data   = s_data;
                w_m_valid  = s_valid;
                w_s_ready  = m_ready;
                w_crc_data = s_data;
                w_crc_en   = s_valid & m_ready;
                if (s_valid && m_ready) begin
                    w_count_nx = w_count_sat;
                    if (s_last) begin
                        if (PAD_EN && (w_count_p1 < c_MIN_LEN)) begin
                            w_state_nx = ST_PAD;
                        end else begin
                            w_state_nx = ST_WAIT;
                        end
                    end
                end
            end
            ST_PAD: begin
                w_m_valid = 1'b1;
                w_crc_en  = m_ready;
                if (m_ready) begin
                    w_count_nx = w_count_sat;
                    if (w_count_p1 >= c_MIN_LEN) begin
                        w_state_nx = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                // CRC core output has settled on the last enabled byte by now
                w_fcs_nx   = crc_in;
                w_idx_nx   = 2'd0;
                w_state_nx = ST_FCS;
            end
            ST_FCS: begin
                w_m_valid = 1'b1;
                w_m_data  = r_fcs[{r_idx, 3'b000} +: 8];
                w_m_last  = (r_idx == 2'd3);
                if (m_ready) begin
                    w_idx_nx = r_idx + 2'd1;
                    if (r_idx == 2'd3) begin
                        w_count_nx = 11'd0;
                        w_state_nx = ST_CLEAR;
                    end
                end
            end
            ST_CLEAR: begin
                w_state_nx = ST_DATA;
            end
            default: begin
                w_state_nx = ST_DATA;
            end
        endcase
    end

    assign m_data    = w_m_data;
    assign crc_data  = w_crc_data;
    assign m_valid   = rst_n & w_m_valid;
    assign m_last    = rst_n & w_m_last;
    assign s_ready   = rst_n & w_s_ready;
    assign crc_en    = rst_n & w_crc_en;
    assign crc_rst_n = rst_n & (r_state != ST_CLEAR);
    assign busy      = rst_n & ~((r_state == ST_DATA) && (r_count == 11'd0));

endmodule
`default_nettype wire

// File: doc/fcs_sequencer.md
FCS_SEQUENCER -- requirements
Module: fcs_sequencer

Interface
REQ-001 Parameter MIN_LEN, default 60, sets the minimum frame length in bytes before FCS; frames shorter than this are zero-padded up to it.
REQ-002 Parameter PAD_EN, default 1, enables padding; when 0, no pad bytes are ever emitted.
REQ-003 clk  in  1  single clock; all logic is rising-edge.
REQ-004 rst_n  in  1  reset; synchronous, active-low.
REQ-005 s_data  in  8  upstream frame byte (DA through payload, no preamble/FCS).
REQ-006 s_valid  in  1  s_data valid.
REQ-007 s_last  in  1  s_data is the final frame byte.
REQ-008 s_ready  out  1  block accepts s_data this cycle.
REQ-009 m_data  out  8  downstream byte.
REQ-010 m_valid  out  1  m_data valid.
REQ-011 m_last  out  1  final FCS byte of the frame.
REQ-012 m_ready  in  1  downstream accepts m_data this cycle.
REQ-013 crc_rst_n  out  1  clear to crc32_gen rst_n; active-low.
REQ-014 crc_en  out  1  crc32_gen enable.
REQ-015 crc_data  out  8  crc32_gen data_in.
REQ-016 crc_in  in  32  crc32_gen crc_out: final complemented CRC, valid 1 cycle after the last enabled byte.
REQ-017 busy  out  1  high in every state except DATA with byte count 0.

Function
REQ-018 Transfer rule: a byte moves when valid and ready are both high in the same cycle; a byte is never duplicated or dropped.
REQ-019 FSM states are DATA, PAD, WAIT, FCS and CLEAR; reset enters DATA with byte count 0.
REQ-020 In DATA: m_data=s_data, m_valid=s_valid, s_ready=m_ready, m_last=0, crc_data=s_data, crc_en=s_valid&m_ready.
REQ-021 Byte counter: 11 bits; increments on every data or pad transfer; saturates at 2047; clears on entry to CLEAR.
REQ-022 On a transfer with s_last=1 in DATA: go to PAD if PAD_EN=1 and count+1<MIN_LEN, otherwise go to WAIT.
REQ-023 In PAD: s_ready=0, m_valid=1, m_data=0x00, crc_data=0x00, crc_en=m_ready; when the transfer makes count equal MIN_LEN, go to WAIT.
REQ-024 In WAIT: exactly 1 cycle; m_valid=0, s_ready=0, crc_en=0; on exit, latch crc_in into a 32-bit FCS register and clear the 2-bit FCS byte index.
REQ-025 In FCS: m_valid=1; m_data=FCS register byte [index], index 0 = bits[7:0] (LSB byte first); crc_en=0; s_ready=0.
REQ-026 In FCS: index advances on each transfer; m_last=1 only when index=3; the transfer at index 3 goes to CLEAR.
REQ-027 In CLEAR: exactly 1 cycle; crc_rst_n=0, m_valid=0, s_ready=0; then go to DATA.
REQ-028 crc_rst_n = rst_n AND (state != CLEAR), driven combinationally.
REQ-029 Backpressure: m_ready=0 holds m_data, m_last, the FCS index and the counter stable, and crc_en=0.
REQ-030 Minimum gap between frames: 2 cycles (WAIT and CLEAR) plus 4 FCS transfers.
REQ-031 s_last on the first byte is legal: a 1-byte frame pads to MIN_LEN when PAD_EN=1.

Reset
REQ-032 While rst_n=0 at a clock edge: next state DATA, count 0, index 0, FCS register 0.
REQ-033 Outputs while rst_n=0: m_valid=0, m_last=0, s_ready=0, crc_en=0, crc_rst_n=0, busy=0.
REQ-034 Reset mid-frame discards the partial frame; no FCS is emitted for it; the first byte after reset release starts a new frame against a cleared CRC.

Verification
REQ-035 PAD_EN=0: feed "123456789" (0x31..0x39), m_ready=1 -> 9 bytes out, then 0x26 0x39 0xF4 0xCB with m_last on 0xCB.
REQ-036 PAD_EN=1, MIN_LEN=60: feed a 14-byte header (FF x6, 00 11 22 33 44 55, 08 00) -> 14 bytes, 46 bytes of 0x00, then 4 FCS bytes; 64 bytes total; FCS matches the software CRC-32 of the 60 bytes.
REQ-037 Random m_ready toggling (50%) on REQ-036's frame -> identical byte sequence out; crc_en asserted exactly 60 times.
REQ-038 Two frames back-to-back, s_valid held high -> second FCS equals the CRC of the second frame alone; crc_rst_n low exactly 1 cycle between frames.
REQ-039 Assert rst_n=0 for 1 cycle after 5 bytes, then send "123456789" with PAD_EN=0 -> FCS bytes 26 39 F4 CB; no m_last before them.
REQ-040 Single-byte frame 0x00 with PAD_EN=1 -> 60 bytes of 0x00 out, then 4 FCS bytes, with m_last only on the 64th byte.
